// File: rtl/maxmin_pkg.sv
// rtl/maxmin_pkg.sv - shared states and default sizes for the max/min window scanner
package maxmin_pkg;

    localparam int DEF_DW    = 8;
    localparam int DEF_DEPTH = 256;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DRAIN,
        S_DONE
    } state_t;

endpackage

// File: rtl/maxmin_cmp_unit.sv
// rtl/maxmin_cmp_unit.sv - per-word running max/min with first-occurrence index tracking
module maxmin_cmp_unit
    import maxmin_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int AW = $clog2(DEF_DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          vld,
    input  logic          first,
    input  logic          signed_md,
    input  logic [DW-1:0] data,
    input  logic [AW-1:0] addr,
    output logic [DW-1:0] max_val,
    output logic [DW-1:0] min_val,
    output logic [AW-1:0] max_idx,
    output logic [AW-1:0] min_idx
);

    logic [DW-1:0] max_q, max_d, min_q, min_d;
    logic [AW-1:0] max_idx_q, max_idx_d, min_idx_q, min_idx_d;
    logic [DW:0]   ext_data, ext_max, ext_min;
    logic          gt, lt;

    // One extra bit lets a single signed compare cover both modes.
    always_comb begin
        ext_data = {signed_md & data[DW-1], data};
        ext_max  = {signed_md & max_q[DW-1], max_q};
        ext_min  = {signed_md & min_q[DW-1], min_q};
        gt       = $signed(ext_data) > $signed(ext_max);
        lt       = $signed(ext_data) < $signed(ext_min);
    end

    always_comb begin
        max_d     = max_q;
        min_d     = min_q;
        max_idx_d = max_idx_q;
        min_idx_d = min_idx_q;
        if (clr) begin
            max_d     = '0;
            min_d     = '0;
            max_idx_d = '0;
            min_idx_d = '0;
        end else if (vld) begin
            if (first || gt) begin
                max_d     = data;
                max_idx_d = addr;
            end
            if (first || lt) begin
                min_d     = data;
                min_idx_d = addr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_q     <= '0;
            min_q     <= '0;
            max_idx_q <= '0;
            min_idx_q <= '0;
        end else begin
            max_q     <= max_d;
            min_q     <= min_d;
            max_idx_q <= max_idx_d;
            min_idx_q <= min_idx_d;
        end
    end

    assign max_val = max_q;
    assign min_val = min_q;
    assign max_idx = max_idx_q;
    assign min_idx = min_idx_q;

endmodule

// File: rtl/maxmin_scan_param.sv
// rtl/maxmin_scan_param.sv - window scan controller: FSM, address counter, read-valid pipe
module maxmin_scan_param
    import maxmin_pkg::*;
#(
    parameter  int DW    = DEF_DW,
    parameter  int DEPTH = DEF_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          go,
    input  logic [AW-1:0] base,
    input  logic [AW:0]   len,
    input  logic          signed_md,
    output logic          R_en,
    output logic [AW-1:0] R_Addr,
    input  logic [DW-1:0] R_Data,
    output logic [DW-1:0] max_val,
    output logic [DW-1:0] min_val,
    output logic [AW-1:0] max_idx,
    output logic [AW-1:0] min_idx,
    output logic [DW:0]   max_diff,
    output logic          busy,
    output logic          done,
    output logic          empty
);

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    state_t        state_q, state_d;
    logic [AW-1:0] base_q, base_d;
    logic [AW:0]   len_q, len_d;
    logic [AW:0]   i_q, i_d;
    logic          sgn_q, sgn_d;
    logic          empty_q, empty_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [DW:0]   diff_q, diff_d;
    logic          rd_vld_q, rd_vld_d;
    logic          rd_first_q, rd_first_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic [AW:0]   len_cl;
    logic          clr;

    assign len_cl = (len > DEPTH_L) ? DEPTH_L : len;
    assign R_en   = (state_q == S_SCAN);
    assign R_Addr = R_en ? (base_q + i_q[AW-1:0]) : '0;

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        len_d    = len_q;
        i_d      = i_q;
        sgn_d    = sgn_q;
        empty_d  = empty_q;
        diff_d   = diff_q;
        clr      = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (go) begin
                    base_d = base;
                    len_d  = len_cl;
                    sgn_d  = signed_md;
                    i_d    = '0;
                    if (len_cl == '0) begin
                        state_d = S_DONE;
                        empty_d = 1'b1;
                        diff_d  = '0;
                        clr     = 1'b1;
                    end else begin
                        state_d = S_SCAN;
                        empty_d = 1'b0;
                    end
                end
            end
            S_SCAN: begin
                i_d = i_q + 1'b1;
                if (i_q == len_q - 1'b1) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                // Wait out the last compare so the difference sees final max/min.
                if (!rd_vld_q) begin
                    state_d = S_DONE;
                    diff_d  = {sgn_q & max_val[DW-1], max_val} - {sgn_q & min_val[DW-1], min_val};
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d     = (state_d == S_SCAN) || (state_d == S_DRAIN);
        done_d     = (state_d == S_DONE);
        rd_vld_d   = R_en;
        rd_first_d = R_en && (i_q == '0);
        rd_addr_d  = R_Addr;
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            len_q      <= '0;
            i_q        <= '0;
            sgn_q      <= 1'b0;
            empty_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            diff_q     <= '0;
            rd_vld_q   <= 1'b0;
            rd_first_q <= 1'b0;
            rd_addr_q  <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            len_q      <= len_d;
            i_q        <= i_d;
            sgn_q      <= sgn_d;
            empty_q    <= empty_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            diff_q     <= diff_d;
            rd_vld_q   <= rd_vld_d;
            rd_first_q <= rd_first_d;
            rd_addr_q  <= rd_addr_d;
        end
    end

    maxmin_cmp_unit #(
        .DW (DW),
        .AW (AW)
    ) u_cmp (
        .clk       (Clk),
        .rst_n     (Rst),
        .clr       (clr),
        .vld       (rd_vld_q),
        .first     (rd_first_q),
        .signed_md (sgn_q),
        .data      (R_Data),
        .addr      (rd_addr_q),
        .max_val   (max_val),
        .min_val   (min_val),
        .max_idx   (max_idx),
        .min_idx   (min_idx)
    );

    assign max_diff = diff_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign empty    = empty_q;

endmodule

// File: tb/tb_maxmin_scan_param.sv
// tb/tb_maxmin_scan_param.sv - scoreboard bench for maxmin_scan_param with a 1-cycle register file
module tb_maxmin_scan_param;

    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic       go = 1'b0;
    logic [7:0] base = '0;
    logic [8:0] len = '0;
    logic       signed_md = 1'b0;
    logic       R_en;
    logic [7:0] R_Addr;
    logic [7:0] R_Data;
    logic [7:0] max_val, min_val, max_idx, min_idx;
    logic [8:0] max_diff;
    logic       busy, done, empty;

    typedef struct {
        int mx;
        int mn;
        int mxi;
        int mni;
        int diff;
        int emp;
        int lat;
        int nrd;
    } exp_t;

    exp_t       sb[$];
    int         addr_log[$];
    logic [7:0] rf[256];
    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc;

    always #5 Clk = ~Clk;

    maxmin_scan_param dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .go        (go),
        .base      (base),
        .len       (len),
        .signed_md (signed_md),
        .R_en      (R_en),
        .R_Addr    (R_Addr),
        .R_Data    (R_Data),
        .max_val   (max_val),
        .min_val   (min_val),
        .max_idx   (max_idx),
        .min_idx   (min_idx),
        .max_diff  (max_diff),
        .busy      (busy),
        .done      (done),
        .empty     (empty)
    );

    always @(posedge Clk) if (R_en) R_Data <= rf[R_Addr];
    always @(negedge Clk) if (R_en) addr_log.push_back(int'(R_Addr));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input int b, input int l, input bit sm);
        exp_t e;
        int   n, a, v;
        e = '{default: 0};
        n = (l > 256) ? 256 : l;
        e.nrd = n;
        if (n == 0) begin
            e.emp = 1;
            return e;
        end
        e.lat = n + 2;
        for (int j = 0; j < n; j++) begin
            a = (b + j) % 256;
            v = sm ? int'($signed(rf[a])) : int'(rf[a]);
            if (j == 0 || v > e.mx) begin e.mx = v; e.mxi = a; end
            if (j == 0 || v < e.mn) begin e.mn = v; e.mni = a; end
        end
        e.diff = e.mx - e.mn;
        e.mx = e.mx & 8'hFF;
        e.mn = e.mn & 8'hFF;
        return e;
    endfunction

    task automatic start(input int b, input int l, input bit sm);
        @(negedge Clk);
        go = 1'b1;
        base = b[7:0];
        len = l[8:0];
        signed_md = sm;
        addr_log.delete();
        sb.push_back(model(b, l, sm));
        @(posedge Clk);
        #1;
        go = 1'b0;
    endtask

    task automatic wait_done(input int cyc0);
        cyc = cyc0;
        while (!done && cyc < 600) begin
            @(posedge Clk);
            #1;
            cyc++;
        end
        check("done_timeout", (cyc >= 600), 0);
    endtask

    task automatic finish_scan();
        exp_t e;
        check("sb_nonempty", (sb.size() > 0), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("latency", cyc, e.lat);
            check("max_val", max_val, e.mx);
            check("min_val", min_val, e.mn);
            check("max_idx", max_idx, e.mxi);
            check("min_idx", min_idx, e.mni);
            check("max_diff", max_diff, e.diff);
            check("empty", empty, e.emp);
            check("busy", busy, 0);
            check("reads", addr_log.size(), e.nrd);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rf[i] = i[7:0];
        repeat (2) @(posedge Clk);
        #1;
        check("rst_outs", {R_en, R_Addr, max_val, min_val, max_idx, min_idx, max_diff, busy, done, empty}, 0);
        @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        check("idle_outs", {R_en, busy, done, empty}, 0);

        start(0, 256, 0);
        wait_done(0);
        finish_scan();
        check("t1_max", {max_val, max_idx, min_val, min_idx, max_diff}, {8'd255, 8'd255, 8'd0, 8'd0, 9'd255});
        check("t1_lat", cyc, 258);

        for (int i = 0; i < 256; i++) rf[i] = 8'h05;
        rf[10] = 8'h80;
        rf[11] = 8'h7F;
        start(8, 8, 1);
        wait_done(0);
        finish_scan();
        check("t2_signed", {max_val, max_idx, min_val, min_idx, max_diff}, {8'h7F, 8'd11, 8'h80, 8'd10, 9'd255});
        start(8, 8, 0);
        wait_done(0);
        finish_scan();
        check("t2_unsigned", {max_val, max_idx, min_val, min_idx, max_diff}, {8'h80, 8'd10, 8'h05, 8'd8, 9'd123});

        for (int i = 0; i < 256; i++) rf[i] = 8'h33;
        start(3, 5, 0);
        wait_done(0);
        finish_scan();
        check("t3_ties", {max_idx, min_idx, max_diff}, {8'd3, 8'd3, 9'd0});

        for (int i = 0; i < 256; i++) rf[i] = 8'h10;
        rf[1] = 8'hF0;
        rf[254] = 8'h01;
        start(254, 4, 0);
        wait_done(0);
        finish_scan();
        check("t4_addrs", {addr_log[0][7:0], addr_log[1][7:0], addr_log[2][7:0], addr_log[3][7:0]},
              {8'd254, 8'd255, 8'd0, 8'd1});
        check("t4_res", {max_val, max_idx, min_val, min_idx}, {8'hF0, 8'd1, 8'h01, 8'd254});

        start(20, 0, 0);
        wait_done(0);
        finish_scan();
        check("t5_empty", {done, empty, R_en}, 3'b110);
        start(5, 1, 1);
        wait_done(0);
        finish_scan();
        check("t5_len1_lat", cyc, 3);

        for (int i = 0; i < 256; i++) rf[i] = 8'(i * 37 + 11);
        start(200, 300, 1);
        wait_done(0);
        finish_scan();
        start(77, 40, 0);
        wait_done(0);
        finish_scan();

        start(0, 200, 0);
        repeat (10) @(posedge Clk);
        #3;
        Rst = 1'b0;
        #1;
        check("midrst_outs", {R_en, R_Addr, max_val, min_val, max_idx, min_idx, max_diff, busy, done, empty}, 0);
        void'(sb.pop_front());
        @(negedge Clk);
        Rst = 1'b1;

        start(30, 20, 0);
        repeat (5) @(posedge Clk);
        #1;
        go = 1'b1;
        base = 8'd100;
        len = 9'd3;
        @(posedge Clk);
        #1;
        go = 1'b0;
        check("go_ignored_busy", busy, 1);
        wait_done(6);
        finish_scan();

        repeat (3) @(posedge Clk);
        #1;
        check("done_hold", {done, busy}, 2'b10);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
